// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package inst_fetch_pkg;

  localparam int unsigned IW         = 8;
  localparam int unsigned DEFAULT_AW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_if.sv
// Memory-side and decoder-side signals of the fetch unit.
interface inst_fetch_if
  import inst_fetch_pkg::*;
#(
  parameter int unsigned AW = DEFAULT_AW
);

  logic [AW-1:0] imem_addr;
  logic          imem_req;
  logic          imem_ack;
  logic [IW-1:0] imem_data;
  logic [IW-1:0] ir;
  logic          ir_valid;
  logic          ir_ready;
  logic [AW-1:0] pc;

  modport master (
    output imem_addr,
    output imem_req,
    input  imem_ack,
    input  imem_data,
    output ir,
    output ir_valid,
    input  ir_ready,
    output pc
  );

  modport slave (
    input  imem_addr,
    input  imem_req,
    output imem_ack,
    output imem_data,
    input  ir,
    input  ir_valid,
    output ir_ready,
    input  pc
  );

endinterface

// File: rtl/inst_fetch_program_counter.sv
// Fetch address counter: load beats increment, wraps modulo 2^AW.
module program_counter #(
  parameter int unsigned   AW       = 8,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          load_i,
  input  logic [AW-1:0] load_addr_i,
  input  logic          inc_i,
  output logic [AW-1:0] fetch_pc_o
);

  logic [AW-1:0] fetch_pc_q;
  logic [AW-1:0] fetch_pc_d;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (load_i) begin
      fetch_pc_d = load_addr_i;
    end else if (inc_i) begin
      fetch_pc_d = fetch_pc_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      fetch_pc_q <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
    end
  end

  assign fetch_pc_o = fetch_pc_q;

endmodule

// File: rtl/inst_fetch.sv
// Single-outstanding instruction fetch: request a byte, hold it in ir until
// the decoder takes it; redirects reload the fetch address and kill stale data.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int unsigned   AW       = DEFAULT_AW,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          run,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_addr,
  inst_fetch_if.master  bus
);

  fetch_state_e  state_q, state_d;
  logic          kill_q, kill_d;
  logic [IW-1:0] ir_q, ir_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          ir_valid_q;
  logic          imem_req_q;
  logic          pc_inc;
  logic [AW-1:0] fetch_pc;

  program_counter #(
    .AW       (AW),
    .RESET_PC (RESET_PC)
  ) u_program_counter (
    .clk         (clk),
    .clr         (clr),
    .load_i      (redirect),
    .load_addr_i (redirect_addr),
    .inc_i       (pc_inc),
    .fetch_pc_o  (fetch_pc)
  );

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    pc_inc  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (run) state_d = REQ;
      end
      REQ: begin
        if (bus.imem_ack) begin
          kill_d = 1'b0;
          // A redirect seen during this request (or on the ack itself) makes the data stale.
          if (kill_q || redirect) begin
            state_d = run ? REQ : IDLE;
          end else begin
            ir_d    = bus.imem_data;
            pc_d    = fetch_pc;
            pc_inc  = 1'b1;
            state_d = HOLD;
          end
        end else if (redirect) begin
          kill_d = 1'b1;
        end
      end
      HOLD: begin
        if (redirect || bus.ir_ready) state_d = run ? REQ : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with state_q.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= IDLE;
      kill_q     <= 1'b0;
      ir_q       <= '0;
      pc_q       <= RESET_PC;
      ir_valid_q <= 1'b0;
      imem_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      kill_q     <= kill_d;
      ir_q       <= ir_d;
      pc_q       <= pc_d;
      ir_valid_q <= (state_d == HOLD);
      imem_req_q <= (state_d == REQ);
    end
  end

  assign bus.imem_addr = fetch_pc;
  assign bus.imem_req  = imem_req_q;
  assign bus.ir        = ir_q;
  assign bus.ir_valid  = ir_valid_q;
  assign bus.pc        = pc_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed and randomized checks of inst_fetch against a transaction-level model.
module tb_inst_fetch;

  logic       clk = 1'b0;
  logic       clr;
  logic       run;
  logic       redirect;
  logic [7:0] redirect_addr;

  inst_fetch_if #(.AW(8)) bus ();

  inst_fetch #(
    .AW       (8),
    .RESET_PC (8'h00)
  ) dut (
    .clk           (clk),
    .clr           (clr),
    .run           (run),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  int         checks = 0;
  int         errors = 0;
  int         lat = 0;
  int         req_cnt = 0;
  logic       force_ack = 1'b0;
  logic       ack_given = 1'b0;
  logic       was_req;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory responder acks a pending request after 'lat' waiting cycles.
  task automatic tick();
    ack_given = 1'b0;
    if (force_ack) begin
      bus.imem_ack  = 1'b1;
      bus.imem_data = 8'h5A;
    end else if (bus.imem_req === 1'b1 && req_cnt >= lat) begin
      bus.imem_ack  = 1'b1;
      bus.imem_data = mem[bus.imem_addr];
      ack_given     = 1'b1;
    end else begin
      bus.imem_ack  = 1'b0;
      bus.imem_data = 8'($urandom);
    end
    was_req = bus.imem_req;
    @(posedge clk);
    #1;
    if (clr || ack_given) req_cnt = 0;
    else if (was_req) req_cnt++;
    bus.imem_ack = 1'b0;
  endtask

  logic [7:0] exp_fa;
  logic       tainted;
  logic       deliver_exp;
  logic       req_b, iv_b;
  logic [7:0] addr_b, ir_b, pc_b;
  int         deliver_cnt;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    clr = 1'b1; run = 1'b0; redirect = 1'b0; redirect_addr = 8'h00;
    bus.ir_ready = 1'b0; bus.imem_ack = 1'b0; bus.imem_data = 8'h00;
    tick(); tick();
    chk("rst_req", bus.imem_req, 0);
    chk("rst_valid", bus.ir_valid, 0);
    chk("rst_ir", bus.ir, 8'h00);
    chk("rst_pc", bus.pc, 8'h00);
    chk("rst_addr", bus.imem_addr, 8'h00);

    // Streaming fetch with single-cycle ack and ready held high
    clr = 1'b0; run = 1'b1; bus.ir_ready = 1'b1; lat = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("s_req", bus.imem_req, 1);
      chk("s_addr", bus.imem_addr, 8'(k));
      chk("s_valid_lo", bus.ir_valid, 0);
      tick();
      chk("s_valid_hi", bus.ir_valid, 1);
      chk("s_ir", bus.ir, mem[k]);
      chk("s_pc", bus.pc, 8'(k));
      chk("s_req_lo", bus.imem_req, 0);
    end

    // Decoder stall in HOLD
    bus.ir_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("h_ir", bus.ir, mem[5]);
      chk("h_pc", bus.pc, 8'h05);
      chk("h_valid", bus.ir_valid, 1);
      chk("h_req", bus.imem_req, 0);
      chk("h_addr", bus.imem_addr, 8'h06);
    end
    bus.ir_ready = 1'b1;
    tick();
    chk("h_resume_addr", bus.imem_addr, 8'h06);
    tick();
    chk("h_resume_pc", bus.pc, 8'h06);

    // Redirect during a slow request
    lat = 3;
    tick();
    chk("k_addr0", bus.imem_addr, 8'h07);
    redirect = 1'b1; redirect_addr = 8'h40;
    tick();
    redirect = 1'b0;
    chk("k_req_kept", bus.imem_req, 1);
    chk("k_addr_tgt", bus.imem_addr, 8'h40);
    tick(); tick();
    chk("k_wait_valid", bus.ir_valid, 0);
    tick();
    chk("k_disc_valid", bus.ir_valid, 0);
    chk("k_disc_req", bus.imem_req, 1);
    chk("k_disc_addr", bus.imem_addr, 8'h40);
    chk("k_disc_ir", bus.ir, mem[6]);
    chk("k_disc_pc", bus.pc, 8'h06);
    for (int k = 0; k < 8 && bus.ir_valid !== 1'b1; k++) begin
      if (bus.imem_req === 1'b1) chk("k_refetch_addr", bus.imem_addr, 8'h40);
      tick();
    end
    chk("k_valid", bus.ir_valid, 1);
    chk("k_pc", bus.pc, 8'h40);
    chk("k_ir", bus.ir, mem[8'h40]);

    // Fetch at the top of the address space wraps to zero
    lat = 0; redirect = 1'b1; redirect_addr = 8'hFF;
    tick();
    redirect = 1'b0;
    chk("w_valid_clr", bus.ir_valid, 0);
    chk("w_addr", bus.imem_addr, 8'hFF);
    tick();
    chk("w_pc", bus.pc, 8'hFF);
    chk("w_ir", bus.ir, mem[8'hFF]);
    tick();
    chk("w_next_addr", bus.imem_addr, 8'h00);
    tick();
    chk("w_next_pc", bus.pc, 8'h00);

    // run dropped while a request is outstanding
    tick();
    chk("r_addr", bus.imem_addr, 8'h01);
    run = 1'b0;
    tick();
    chk("r_valid", bus.ir_valid, 1);
    chk("r_pc", bus.pc, 8'h01);
    tick();
    chk("r_idle_valid", bus.ir_valid, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("r_idle_req", bus.imem_req, 0);
      chk("r_idle_addr", bus.imem_addr, 8'h02);
    end

    // clr wins over redirect/ready in HOLD; stray ack in IDLE ignored
    run = 1'b1; bus.ir_ready = 1'b0;
    tick(); tick();
    chk("c_hold_pc", bus.pc, 8'h02);
    clr = 1'b1; redirect = 1'b1; redirect_addr = 8'h77; bus.ir_ready = 1'b1;
    tick();
    chk("c_req", bus.imem_req, 0);
    chk("c_valid", bus.ir_valid, 0);
    chk("c_ir", bus.ir, 8'h00);
    chk("c_pc", bus.pc, 8'h00);
    chk("c_addr", bus.imem_addr, 8'h00);
    clr = 1'b0; redirect = 1'b0; run = 1'b0; bus.ir_ready = 1'b0; force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    chk("c_stray_valid", bus.ir_valid, 0);
    chk("c_stray_ir", bus.ir, 8'h00);
    chk("c_stray_req", bus.imem_req, 0);

    // clr abandons an in-flight request
    run = 1'b1; lat = 3;
    tick();
    chk("m_req", bus.imem_req, 1);
    clr = 1'b1;
    tick();
    chk("m_req_clr", bus.imem_req, 0);
    clr = 1'b0; run = 1'b0; force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    chk("m_stray_valid", bus.ir_valid, 0);
    chk("m_stray_ir", bus.ir, 8'h00);
    chk("m_stray_req", bus.imem_req, 0);

    // Randomized traffic against an address-level model
    clr = 1'b1; tick(); clr = 1'b0;
    exp_fa = 8'h00; tainted = 1'b0; deliver_cnt = 0;
    for (int n = 0; n < 600; n++) begin
      run           = ($urandom_range(0, 7) != 0);
      bus.ir_ready  = ($urandom_range(0, 2) != 0);
      redirect      = ($urandom_range(0, 9) == 0);
      redirect_addr = 8'($urandom);
      lat           = $urandom_range(0, 2);
      req_b = bus.imem_req; addr_b = bus.imem_addr;
      iv_b = bus.ir_valid; ir_b = bus.ir; pc_b = bus.pc;
      if (req_b) chk("x_addr", addr_b, exp_fa);
      tick();
      if (req_b && redirect) tainted = 1'b1;
      deliver_exp = ack_given && !tainted;
      if (ack_given) tainted = 1'b0;
      if (deliver_exp) begin
        chk("x_pc", bus.pc, exp_fa);
        chk("x_ir", bus.ir, mem[exp_fa]);
        exp_fa = exp_fa + 8'd1;
        deliver_cnt++;
      end else begin
        chk("x_ir_hold", bus.ir, ir_b);
        chk("x_pc_hold", bus.pc, pc_b);
      end
      if (redirect) exp_fa = redirect_addr;
      chk("x_valid", bus.ir_valid, deliver_exp || (iv_b && !bus.ir_ready && !redirect));
      if (req_b && !ack_given) chk("x_req_kept", bus.imem_req, 1);
      chk("x_excl", bus.ir_valid && bus.imem_req, 0);
    end
    redirect = 1'b0;
    chk("x_progress", deliver_cnt > 40, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
